paddle_link: RTL and testbench

//  Board-to-board serial link for two-player mode. Sends local paddle state (ypos_one,

---
 rtl/paddle_link.sv | 256 +++++++++++++++++++++++++
 tb/tb_paddle_link.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_link.sv
// paddle_link: UART link carrying local paddle state to the peer board.
// Define LINK_PARITY_EN to add an even parity bit to every character.
module paddle_link #(
   parameter int CLK_HZ     = 65_000_000,
   parameter int BAUD       = 115_200,
   parameter int RESEND_CYC = 1_083_333,
   parameter int TIMEOUT    = 6_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] ypos_in,
   input  logic       left_in,
   input  logic       rx,
   output logic       tx,
   output logic [9:0] ypos_sec,
   output logic       left_sec,
   output logic       rx_valid,
   output logic       link_up,
   output logic       frame_err
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam int RW  = $clog2(RESEND_CYC + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);
`ifdef LINK_PARITY_EN
   localparam logic [3:0] LAST = 4'd10;
`else
   localparam logic [3:0] LAST = 4'd9;
`endif
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
   localparam logic [RW-1:0] RES_MAX  = RW'(RESEND_CYC);
   localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {WAIT_SYNC, GET_HI, GET_LO, GET_CHK} p_state_t;

   tx_state_t   tx_state;
   logic [CW-1:0] tx_cnt;
   logic [3:0]  tx_bit;
   logic [1:0]  tx_chr;
   logic [10:0] snap;
   logic [10:0] last;
   logic [RW-1:0] rtim;
   logic [10:0] cur;
   logic        start;
   logic [7:0]  hi;
   logic [7:0]  tx_byte;

   rx_state_t   rx_state;
   p_state_t    p_state;
   logic        rs1, rs2, rprev;
   logic [CW-1:0] rcnt;
   logic [3:0]  rbit;
   logic [7:0]  rsh;
   logic [7:0]  hi_r, lo_r;
   logic [TW-1:0] wd;
   logic        stop_tick;
   logic        byte_bad;
   logic        chk_ok;
`ifdef LINK_PARITY_EN
   logic        par_bad;
`endif

   // Line level of bit i of a character carrying byte b.
   function automatic logic bit_of(input logic [7:0] b,
                                   input logic [3:0] i);
      if (i == 4'd0) return 1'b0;
      if (i <= 4'd8) return b[3'(i - 4'd1)];
`ifdef LINK_PARITY_EN
      if (i == 4'd9) return ^b;
`endif
      return 1'b1;
   endfunction

   assign cur   = {left_in, ypos_in};
   assign start = (cur != last) || (rtim >= RES_MAX);

   // Byte of the frame currently being serialised.
   always_comb begin
      hi = {5'b0, snap[10:8]};
      unique case (tx_chr)
         2'd0:    tx_byte = 8'hA5;
         2'd1:    tx_byte = hi;
         2'd2:    tx_byte = snap[7:0];
         default: tx_byte = hi ^ snap[7:0] ^ 8'h5A;
      endcase
   end

   // Transmit FSM with resend timer; tx is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_chr   <= '0;
         snap     <= '0;
         last     <= '0;
         rtim     <= '0;
      end else begin
         if (rtim != RES_MAX) rtim <= rtim + RW'(1);
         unique case (tx_state)
            TX_IDLE: if (start) begin
               rtim     <= '0;
               snap     <= cur;
               last     <= cur;
               tx       <= 1'b0;
               tx_cnt   <= '0;
               tx_bit   <= '0;
               tx_chr   <= '0;
               tx_state <= TX_SEND;
            end
            TX_SEND: if (tx_cnt == BIT_END) begin
               tx_cnt <= '0;
               if (tx_bit == LAST) begin
                  tx_bit <= '0;
                  if (tx_chr == 2'd3) begin
                     tx_state <= TX_IDLE;
                  end else begin
                     tx_chr <= tx_chr + 2'd1;
                     tx     <= 1'b0;
                  end
               end else begin
                  tx_bit <= tx_bit + 4'd1;
                  tx     <= bit_of(tx_byte, tx_bit + 4'd1);
               end
            end else begin
               tx_cnt <= tx_cnt + CW'(1);
            end
         endcase
      end
   end

   // Two-flop synchroniser plus previous level for edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs1   <= 1'b1;
         rs2   <= 1'b1;
         rprev <= 1'b1;
      end else begin
         rs1   <= rx;
         rs2   <= rs1;
         rprev <= rs2;
      end
   end

   // Receive bit engine: mid-bit sampling from the start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state <= RX_IDLE;
         rcnt     <= '0;
         rbit     <= '0;
         rsh      <= '0;
`ifdef LINK_PARITY_EN
         par_bad  <= 1'b0;
`endif
      end else begin
         unique case (rx_state)
            RX_IDLE: if (rprev && !rs2) begin
               rcnt     <= '0;
               rx_state <= RX_START;
            end
            RX_START: if (rcnt == HALF_END) begin
               rcnt     <= '0;
               rbit     <= '0;
`ifdef LINK_PARITY_EN
               par_bad  <= 1'b0;
`endif
               rx_state <= rs2 ? RX_IDLE : RX_DATA;
            end else begin
               rcnt <= rcnt + CW'(1);
            end
            RX_DATA: if (rcnt == BIT_END) begin
               rcnt <= '0;
               rbit <= rbit + 4'd1;
               if (rbit < 4'd8) rsh <= {rs2, rsh[7:1]};
`ifdef LINK_PARITY_EN
               else par_bad <= (^rsh) ^ rs2;
               if (rbit == 4'd8) rx_state <= RX_STOP;
`else
               if (rbit == 4'd7) rx_state <= RX_STOP;
`endif
            end else begin
               rcnt <= rcnt + CW'(1);
            end
            RX_STOP: if (rcnt == BIT_END) begin
               rcnt     <= '0;
               rx_state <= RX_IDLE;
            end else begin
               rcnt <= rcnt + CW'(1);
            end
         endcase
      end
   end

   assign stop_tick = (rx_state == RX_STOP) && (rcnt == BIT_END);
   assign chk_ok    = rsh == (hi_r ^ lo_r ^ 8'h5A);
`ifdef LINK_PARITY_EN
   assign byte_bad  = !rs2 || par_bad;
`else
   assign byte_bad  = !rs2;
`endif

   // Frame parser, peer outputs and link watchdog.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_state   <= WAIT_SYNC;
         hi_r      <= '0;
         lo_r      <= '0;
         ypos_sec  <= '0;
         left_sec  <= 1'b0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         link_up   <= 1'b0;
         wd        <= '0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (wd != WD_MAX) wd <= wd + TW'(1);
         else link_up <= 1'b0;
         if (stop_tick) begin
            if (byte_bad) begin
               frame_err <= 1'b1;
               p_state   <= WAIT_SYNC;
            end else begin
               unique case (p_state)
                  WAIT_SYNC: if (rsh == 8'hA5) p_state <= GET_HI;
                  GET_HI: begin
                     hi_r    <= rsh;
                     p_state <= GET_LO;
                  end
                  GET_LO: begin
                     lo_r    <= rsh;
                     p_state <= GET_CHK;
                  end
                  GET_CHK: begin
                     p_state <= WAIT_SYNC;
                     if (chk_ok) begin
                        ypos_sec <= {hi_r[1:0], lo_r};
                        left_sec <= hi_r[2];
                        rx_valid <= 1'b1;
                        link_up  <= 1'b1;
                        wd       <= '0;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_paddle_link.sv
// tb_paddle_link: randomized checks of paddle_link against a frame model.
// Uses small timing parameters so frames and timeouts stay short.
module tb_paddle_link;
   localparam int DIV   = 16;
   localparam int RES   = 1500;
   localparam int TMO   = 2500;
`ifdef LINK_PARITY_EN
   localparam int NB    = 11;
`else
   localparam int NB    = 10;
`endif
   localparam int FLEN  = 4 * NB * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] ypos_in = '0;
   logic       left_in = 1'b0;
   logic       rx_drv = 1'b1;
   logic       loop = 1'b0;
   logic       rx;
   logic       tx;
   logic [9:0] ypos_sec;
   logic       left_sec;
   logic       rx_valid;
   logic       link_up;
   logic       frame_err;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int nvalid = 0;
   int nerr = 0;
   int nboth = 0;
   logic wave [FLEN];

   assign rx = loop ? tx : rx_drv;

   paddle_link #(
      .CLK_HZ(DIV * 100), .BAUD(100),
      .RESEND_CYC(RES), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .ypos_in(ypos_in), .left_in(left_in),
      .rx(rx), .tx(tx), .ypos_sec(ypos_sec), .left_sec(left_sec),
      .rx_valid(rx_valid), .link_up(link_up), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) nvalid++;
      if (frame_err === 1'b1) nerr++;
      if (rx_valid === 1'b1 && frame_err === 1'b1) nboth++;
   end

   function automatic logic [31:0] frame_bytes(input logic [9:0] y,
                                               input logic l);
      logic [7:0] h, lo;
      h  = 8'(l) * 8'd4 + 8'(y / 256);
      lo = 8'(y % 256);
      return {8'hA5, h, lo, h ^ lo ^ 8'h5A};
   endfunction

   function automatic int wave_errs(input logic [31:0] fb);
      logic q[$];
      logic [7:0] b;
      int errs = 0;
      for (int k = 0; k < 4; k++) begin
         b = fb[31 - 8 * k -: 8];
         q.push_back(1'b0);
         for (int i = 0; i < 8; i++) q.push_back(b[i]);
         if (NB == 11) q.push_back(($countones(b) % 2) == 1);
         q.push_back(1'b1);
      end
      for (int t = 0; t < FLEN; t++)
         if (wave[t] !== q[t / DIV]) errs++;
      return errs;
   endfunction

   function automatic logic [31:0] decode_wave();
      logic [31:0] r = '0;
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 8; i++)
            r[31 - 8 * k - 7 + i] = wave[(k * NB + 1 + i) * DIV + DIV / 2];
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic capture_frame(output bit ok, output int t0);
      int n = 0;
      ok = 1'b0;
      t0 = 0;
      @(negedge clk);
      while (tx !== 1'b0 && n < RES + 300) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) return;
      t0 = cyc;
      for (int t = 0; t < FLEN; t++) begin
         wave[t] = tx;
         if (t < FLEN - 1) @(negedge clk);
      end
      ok = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // fault: 0 clean, 1 stop bit low, 2 parity flipped
   task automatic send_byte(input logic [7:0] b, input int fault);
      logic q[$];
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef LINK_PARITY_EN
      q.push_back((^b) ^ (fault == 2));
`endif
      q.push_back(fault != 1);
      foreach (q[i]) begin
         rx_drv = q[i];
         repeat (DIV) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (2 * DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] fb);
      for (int k = 0; k < 4; k++) send_byte(fb[31 - 8 * k -: 8], 0);
   endtask

   task automatic test_reset();
      bit ok;
      int n = 0;
      logic [9:0] y;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({tx, ypos_sec, left_sec, rx_valid, link_up, frame_err} !== 15'h4000)
         $display("FAIL reset_state got %h required 4000",
                  {tx, ypos_sec, left_sec, rx_valid, link_up, frame_err});
      else pass_cnt++;
      y = 10'($urandom_range(1, 1023));
      loop = 1'b1;
      ypos_in = y;
      left_in = 1'b1;
      do_reset();
      wait_valid(FLEN + 200, ok);
      total_cnt++;
      if (ok !== 1'b1 || ypos_sec !== y)
         $display("FAIL reset_setup ypos_sec %h required %h", ypos_sec, y);
      else pass_cnt++;
      ypos_in = y ^ 10'h155;
      repeat (4 * DIV) @(negedge clk);
      while (tx !== 1'b0 && n < RES) begin
         @(negedge clk);
         n++;
      end
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if (tx !== 1'b1)
         $display("FAIL reset_mid_tx tx %b required 1", tx);
      else pass_cnt++;
      total_cnt++;
      if ({ypos_sec, left_sec, rx_valid, link_up, frame_err} !== 14'h0)
         $display("FAIL reset_mid_outputs got %h required 0",
                  {ypos_sec, left_sec, rx_valid, link_up, frame_err});
      else pass_cnt++;
      loop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tx(input logic [9:0] y, input logic l, input bit known);
      bit ok1, ok2;
      int t0, t1, e;
      logic [31:0] d;
      logic [9:0] y2;
      logic l2;
      y2 = y ^ 10'($urandom_range(1, 1023));
      l2 = 1'($urandom);
      loop = 1'b0;
      ypos_in = y;
      left_in = l;
      do_reset();
      fork
         capture_frame(ok1, t0);
         begin
            repeat (100) @(negedge clk);
            ypos_in = y2;
            left_in = l2;
         end
      join
      e = wave_errs(frame_bytes(y, l));
      d = decode_wave();
      total_cnt++;
      if (ok1 !== 1'b1 || e != 0)
         $display("FAIL tx_wave y=%h errs %0d required 0", y, e);
      else pass_cnt++;
      if (known) begin
         total_cnt++;
         if (d !== 32'hA506C79B)
            $display("FAIL tx_known got %h required a506c79b", d);
         else pass_cnt++;
      end
      capture_frame(ok2, t1);
      e = wave_errs(frame_bytes(y2, l2));
      d = decode_wave();
      total_cnt++;
      if (ok2 !== 1'b1 || d !== frame_bytes(y2, l2) || e != 0)
         $display("FAIL tx_next_frame got %h required %h errs %0d",
                  d, frame_bytes(y2, l2), e);
      else pass_cnt++;
   endtask

   task automatic test_loopback(input logic [9:0] y);
      int n0;
      logic l;
      l = 1'($urandom);
      loop = 1'b1;
      ypos_in = y;
      left_in = l;
      do_reset();
      n0 = nvalid;
      repeat (FLEN + 150) @(negedge clk);
      total_cnt++;
      if (nvalid - n0 != 1)
         $display("FAIL loop_count got %0d required 1", nvalid - n0);
      else pass_cnt++;
      total_cnt++;
      if ({link_up, left_sec, ypos_sec} !== {1'b1, l, y})
         $display("FAIL loop_data got %h required %h",
                  {link_up, left_sec, ypos_sec}, {1'b1, l, y});
      else pass_cnt++;
      loop = 1'b0;
   endtask

   task automatic test_bad_chk();
      int v0, e0;
      logic [9:0] y;
      y = 10'($urandom);
      ypos_in = 10'h0;
      left_in = 1'b0;
      do_reset();
      v0 = nvalid;
      send_frame(frame_bytes(y, 1'b0));
      total_cnt++;
      if (nvalid - v0 != 1 || ypos_sec !== y)
         $display("FAIL inject_good ypos %h required %h", ypos_sec, y);
      else pass_cnt++;
      v0 = nvalid;
      e0 = nerr;
      send_frame(32'hA5011000);
      total_cnt++;
      if (nerr - e0 != 1 || nvalid - v0 != 0)
         $display("FAIL bad_chk err %0d valid %0d required 1 0",
                  nerr - e0, nvalid - v0);
      else pass_cnt++;
      total_cnt++;
      if (ypos_sec !== y)
         $display("FAIL bad_chk_hold ypos %h required %h", ypos_sec, y);
      else pass_cnt++;
   endtask

   task automatic test_bad_stop();
      int v0, e0;
      logic [7:0] g;
      logic [9:0] y;
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h3C;
      y = {2'($urandom), 8'hA5};
      v0 = nvalid;
      e0 = nerr;
      send_byte(g, 0);
      send_byte(8'hA5, 1);
      total_cnt++;
      if (nerr - e0 != 1 || nvalid - v0 != 0)
         $display("FAIL bad_stop err %0d valid %0d required 1 0",
                  nerr - e0, nvalid - v0);
      else pass_cnt++;
      send_frame(frame_bytes(y, 1'b1));
      total_cnt++;
      if (nvalid - v0 != 1 || {left_sec, ypos_sec} !== {1'b1, y})
         $display("FAIL after_stop got %h required %h",
                  {left_sec, ypos_sec}, {1'b1, y});
      else pass_cnt++;
   endtask

   task automatic test_parity();
`ifdef LINK_PARITY_EN
      int v0, e0;
      logic [9:0] y;
      y = 10'($urandom);
      v0 = nvalid;
      e0 = nerr;
      send_byte(8'hA5, 2);
      total_cnt++;
      if (nerr - e0 != 1 || nvalid - v0 != 0)
         $display("FAIL parity_err err %0d required 1", nerr - e0);
      else pass_cnt++;
      send_frame(frame_bytes(y, 1'b0));
      total_cnt++;
      if (nvalid - v0 != 1 || ypos_sec !== y)
         $display("FAIL parity_after ypos %h required %h", ypos_sec, y);
      else pass_cnt++;
`endif
   endtask

   task automatic test_timeout();
      bit ok;
      logic [9:0] y;
      y = 10'($urandom_range(1, 1023));
      loop = 1'b1;
      ypos_in = y;
      left_in = 1'b0;
      do_reset();
      wait_valid(FLEN + 200, ok);
      loop = 1'b0;
      total_cnt++;
      if (ok !== 1'b1 || link_up !== 1'b1)
         $display("FAIL link_rise ok %b link_up %b required 1 1", ok, link_up);
      else pass_cnt++;
      repeat (TMO - 20) @(negedge clk);
      total_cnt++;
      if (link_up !== 1'b1)
         $display("FAIL link_early_drop link_up %b required 1", link_up);
      else pass_cnt++;
      repeat (40) @(negedge clk);
      total_cnt++;
      if (link_up !== 1'b0 || ypos_sec !== y)
         $display("FAIL link_timeout link_up %b ypos %h required 0 %h",
                  link_up, ypos_sec, y);
      else pass_cnt++;
   endtask

   task automatic test_resend();
      bit ok1, ok2;
      int t0, t1, e;
      logic [9:0] y;
      logic l;
      y = 10'($urandom_range(1, 1023));
      l = 1'($urandom);
      loop = 1'b0;
      ypos_in = y;
      left_in = l;
      do_reset();
      capture_frame(ok1, t0);
      capture_frame(ok2, t1);
      e = wave_errs(frame_bytes(y, l));
      total_cnt++;
      if (ok1 !== 1'b1 || ok2 !== 1'b1 || t1 - t0 < RES || t1 - t0 > RES + 2)
         $display("FAIL resend_period got %0d required %0d..%0d",
                  t1 - t0, RES, RES + 2);
      else pass_cnt++;
      total_cnt++;
      if (e != 0)
         $display("FAIL resend_wave errs %0d required 0", e);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_tx(10'h2C7, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         test_tx(10'($urandom_range(1, 1023)), 1'($urandom), 1'b0);
      test_loopback(10'h3FF);
      test_loopback(10'($urandom));
      test_bad_chk();
      test_bad_stop();
      test_parity();
      test_timeout();
      test_resend();
      total_cnt++;
      if (nboth != 0)
         $display("FAIL valid_err_overlap got %0d required 0", nboth);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
